uart_byte_tx: RTL

- Serial transmitter for 8N1 asynchronous serial (RS-232 level logic): 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Runs on the 50 MHz system clock.
- Uses the same 3-bit baud_set encoding and divisor table as the receive path, so a looped-back tx line is decoded correctly by the receiver.
- Sits between the host-side byte source (command/response logic) and the tx pin.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_byte_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmit and receive paths.
//   Baud divisor constants (clocks per bit at 50 MHz), baud_lookup() mapping
//   the 3-bit baud_set code to its divisor, 8N1 frame constants, and the
//   transmit FSM state type.
//   With UART_TX_PARITY_EN defined, the state type gains TX_PARITY.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [13:0] BAUD_4800    = 14'd10416;
  localparam logic [13:0] BAUD_9600    = 14'd5208;
  localparam logic [13:0] BAUD_19200   = 14'd2604;
  localparam logic [13:0] BAUD_38400   = 14'd1302;
  localparam logic [13:0] BAUD_57600   = 14'd868;
  localparam logic [13:0] BAUD_115200  = 14'd434;
  localparam logic [13:0] BAUD_DEFAULT = 14'd5208;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

  function automatic logic [13:0] baud_lookup(input logic [2:0] baud_set);
    logic [13:0] div;
    case (baud_set)
      3'd0:    div = BAUD_4800;
      3'd1:    div = BAUD_9600;
      3'd2:    div = BAUD_19200;
      3'd3:    div = BAUD_38400;
      3'd4:    div = BAUD_57600;
      3'd5:    div = BAUD_115200;
      default: div = BAUD_DEFAULT;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer -- divisor counter marking the last clock of each bit period.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (start of a new frame)
//   run        : count enable; the count holds while low
//   divisor    : clocks per bit
//   bit_end    : high during the final clock (count == divisor-1) of a bit
`timescale 1ns/1ps
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        run,
  input  logic [13:0] divisor,
  output logic        bit_end
);

  logic [13:0] cnt_q;
  logic [13:0] cnt_d;

  assign bit_end = run && (cnt_q == (divisor - 14'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_end) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 14'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx -- 8N1 serial byte transmitter, 50 MHz system clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   send_en    : start request, honoured only while busy=0
//   data_byte  : byte to send, latched on acceptance
//   baud_set   : 3-bit baud code (see uart_pkg::baud_lookup), latched on acceptance
//   tx         : registered serial line
//   busy       : frame in progress
//   tx_done    : one-cycle pulse after the stop bit
// Build option: UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
`timescale 1ns/1ps
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter logic        IDLE_LEVEL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_en,
  input  logic [7:0] data_byte,
  input  logic [2:0] baud_set,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  tx_state_e   state_q,   state_d;
  logic [7:0]  data_q,    data_d;
  logic [13:0] baud_q,    baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q,      tx_d;
  logic        busy_q,    busy_d;
  logic        tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q,  parity_d;
`endif

  logic timer_clear;
  logic bit_end;

  uart_bit_timer u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .run     (state_q != TX_IDLE),
    .divisor (baud_q),
    .bit_end (bit_end)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      data_q    <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    timer_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (send_en) begin
          state_d     = TX_START;
          data_d      = data_byte;
          baud_d      = baud_lookup(baud_set);
          bit_idx_d   = '0;
          timer_clear = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d    = ^data_byte;
`endif
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Outputs: decoded from the next state so tx/busy are registered yet change
  // on the same edge as the state itself.
  always_comb begin
    tx_d      = IDLE_LEVEL;
    busy_d    = (state_d != TX_IDLE);
    tx_done_d = (state_q == TX_STOP) && bit_end;
    case (state_d)
      TX_START:  tx_d = START_BIT;
      TX_DATA:   tx_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = parity_d;
`endif
      TX_STOP:   tx_d = STOP_BIT;
      default:   tx_d = IDLE_LEVEL;
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule
